// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port round-robin arbiter in front of one synchronous memory port
//   Requester 0 is the core, requester 1 the loader/DMA; each holds req until a one-cycle ack.
//   Ports: aClock/aReset (sync, active-high); aReq*/aAddr*/aWData*/aWrite* requests;
//   anOutAck*/anOutRData* completions; anOutMem* drive the memory, aMemData returns read data
//   one cycle after the address; anOutBusy (not IDLE); aLock1/anOutLocked loader bus lock.
//   Define ARBITER_LOCK_EN to enable the loader bus lock; otherwise aLock1 is ignored.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aClock,
  input  logic                  aReset,
  input  logic                  aReq0,
  input  logic                  aReq1,
  input  logic [ADDR_WIDTH-1:0] aAddr0,
  input  logic [ADDR_WIDTH-1:0] aAddr1,
  input  logic [DATA_WIDTH-1:0] aWData0,
  input  logic [DATA_WIDTH-1:0] aWData1,
  input  logic                  aWrite0,
  input  logic                  aWrite1,
  input  logic                  aLock1,
  output logic                  anOutAck0,
  output logic                  anOutAck1,
  output logic [DATA_WIDTH-1:0] anOutRData0,
  output logic [DATA_WIDTH-1:0] anOutRData1,
  output logic [ADDR_WIDTH-1:0] anOutMemAddress,
  output logic [DATA_WIDTH-1:0] anOutMemData,
  output logic                  anOutMemWrite,
  input  logic [DATA_WIDTH-1:0] aMemData,
  output logic                  anOutBusy,
  output logic                  anOutLocked
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;
  logic [1:0]            state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  win_q, win_d;
  logic                  op_write_q, op_write_d;
  logic                  lock_q, lock_d;
  logic                  mem_write_q, mem_write_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  lock_en;
  logic                  grant0, grant1, pick;
`ifdef ARBITER_LOCK_EN
  assign lock_en = aLock1;
`else
  logic unused_lock;
  assign unused_lock = aLock1;
  assign lock_en = 1'b0;
`endif
  // A held lock survives only while aLock1 stays high, so an IDLE edge with aLock1=0
  // releases the core in that same cycle.
  assign grant0 = aReq0 & ~(lock_q & lock_en);
  assign grant1 = aReq1;
  assign pick = grant1 & (~grant0 | ptr_q);
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    op_write_d  = op_write_q;
    lock_d      = lock_q;
    mem_write_d = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        lock_d = lock_q & lock_en;
        if (grant0 | grant1) begin
          win_d       = pick;
          ptr_d       = ~pick;
          addr_d      = pick ? aAddr1 : aAddr0;
          wdata_d     = pick ? aWData1 : aWData0;
          op_write_d  = pick ? aWrite1 : aWrite0;
          mem_write_d = pick ? aWrite1 : aWrite0;
          lock_d      = (lock_q & lock_en) | (pick & lock_en);
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rdata0_d = (!op_write_q && !win_q) ? aMemData : rdata0_q;
        rdata1_d = (!op_write_q && win_q) ? aMemData : rdata1_q;
        ack0_d   = ~win_q;
        ack1_d   = win_q;
        state_d  = ACK;
      end
      ACK: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aClock) begin
    if (aReset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      op_write_q  <= 1'b0;
      lock_q      <= 1'b0;
      mem_write_q <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      op_write_q  <= op_write_d;
      lock_q      <= lock_d;
      mem_write_q <= mem_write_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end
  assign anOutAck0       = ack0_q;
  assign anOutAck1       = ack1_q;
  assign anOutRData0     = rdata0_q;
  assign anOutRData1     = rdata1_q;
  assign anOutMemAddress = addr_q;
  assign anOutMemData    = wdata_q;
  assign anOutMemWrite   = mem_write_q;
  assign anOutBusy       = state_q != IDLE;
  assign anOutLocked     = lock_q;
endmodule
